// File: rtl/cmp_rr_scheduler_if.sv
// Request, comparator and response signal bundle for cmp_rr_scheduler.
// The master side is the requester/comparator environment; the slave side is the scheduler.
interface cmp_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) ();
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*(WIDTH+1)-1:0] req_a;
    logic [NREQ*(WIDTH+1)-1:0] req_b;
    logic [WIDTH:0]            cmp_a;
    logic [WIDTH:0]            cmp_b;
    logic                      cmp_greater;
    logic [NREQ-1:0]           rsp_valid;
    logic                      rsp_greater;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output cmp_greater,
        input  req_ready,
        input  cmp_a,
        input  cmp_b,
        input  rsp_valid,
        input  rsp_greater
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  cmp_greater,
        output req_ready,
        output cmp_a,
        output cmp_b,
        output rsp_valid,
        output rsp_greater
    );
endinterface

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one external registered FP greater-than comparator among NREQ requesters.
// Optional statistics counters (grant_cnt, conflict_cnt) are built when CMP_RR_STAT_EN is defined.
module cmp_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    cmp_rr_scheduler_if.slave bus
`ifdef CMP_RR_STAT_EN
    ,
    output logic [15:0]       grant_cnt,
    output logic [15:0]       conflict_cnt
`endif
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OPW  = WIDTH + 1;
    localparam int TAGD = LAT + 1;

    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic [IDXW-1:0] rr_ptr_q;
    logic [IDXW-1:0] rr_ptr_d;
    logic            gnt_found_s;
    logic [IDXW-1:0] gnt_idx_s;
    logic [IDXW:0]   cand_s;
    logic [NREQ-1:0] gnt_s;
    logic [OPW-1:0]  sel_a_s;
    logic [OPW-1:0]  sel_b_s;
    logic [OPW-1:0]  cmp_a_q;
    logic [OPW-1:0]  cmp_a_d;
    logic [OPW-1:0]  cmp_b_q;
    logic [OPW-1:0]  cmp_b_d;
    logic [TAGD-1:0] tag_v_q;
    logic [TAGD-1:0] tag_v_d;
    logic [IDXW-1:0] tag_idx_q [TAGD];
    logic [IDXW-1:0] tag_idx_d [TAGD];
    logic [NREQ-1:0] rsp_valid_q;
    logic [NREQ-1:0] rsp_valid_d;
    logic            rsp_greater_q;
    logic            rsp_greater_d;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
            if (cand_s >= (IDXW+1)'(NREQ)) begin
                cand_s = cand_s - (IDXW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && bus.req_valid[cand_s[IDXW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s[IDXW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Grant is held off entirely while reset is asserted.
    always_comb begin
        gnt_s = '0;
        if (rst && gnt_found_s) begin
            gnt_s = idx_onehot(gnt_idx_s);
        end else begin
            gnt_s = '0;
        end
    end

    assign sel_a_s = bus.req_a[gnt_idx_s*OPW +: OPW];
    assign sel_b_s = bus.req_b[gnt_idx_s*OPW +: OPW];

    // Next-state: pointer advance, operand capture, tag shift and response formation.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        if (gnt_found_s) begin
            rr_ptr_d = (gnt_idx_s == IDXW'(NREQ-1)) ? '0 : gnt_idx_s + IDXW'(1);
            cmp_a_d  = sel_a_s;
            cmp_b_d  = sel_b_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
            cmp_a_d  = cmp_a_q;
            cmp_b_d  = cmp_b_q;
        end

        // Tag pipe is one stage deeper than the comparator so its end lines up with cmp_greater.
        tag_v_d      = {tag_v_q[TAGD-2:0], gnt_found_s};
        tag_idx_d[0] = gnt_idx_s;
        for (int s = 1; s < TAGD; s++) begin
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        rsp_valid_d   = '0;
        rsp_greater_d = 1'b0;
        if (tag_v_q[TAGD-1]) begin
            rsp_valid_d   = idx_onehot(tag_idx_q[TAGD-1]);
            rsp_greater_d = bus.cmp_greater;
        end else begin
            rsp_valid_d   = '0;
            rsp_greater_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            cmp_a_q       <= '0;
            cmp_b_q       <= '0;
            tag_v_q       <= '0;
            for (int s = 0; s < TAGD; s++) begin
                tag_idx_q[s] <= '0;
            end
            rsp_valid_q   <= '0;
            rsp_greater_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cmp_a_q       <= cmp_a_d;
            cmp_b_q       <= cmp_b_d;
            tag_v_q       <= tag_v_d;
            for (int s = 0; s < TAGD; s++) begin
                tag_idx_q[s] <= tag_idx_d[s];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_greater_q <= rsp_greater_d;
        end
    end

    assign bus.req_ready   = gnt_s;
    assign bus.cmp_a       = cmp_a_q;
    assign bus.cmp_b       = cmp_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_greater = rsp_greater_q;

`ifdef CMP_RR_STAT_EN
    function automatic logic multi_hot(input logic [NREQ-1:0] vec);
        return (vec & (vec - NREQ'(1))) != '0;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        logic [15:0] res;
        res = cnt;
        if (en && (cnt != 16'hFFFF)) begin
            res = cnt + 16'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [15:0] grant_cnt_q;
    logic [15:0] grant_cnt_d;
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

    // Saturating grant and contention counters.
    always_comb begin
        grant_cnt_d    = sat_inc(grant_cnt_q, gnt_found_s);
        conflict_cnt_d = sat_inc(conflict_cnt_q, multi_hot(bus.req_valid));
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt_q    <= 16'h0000;
            conflict_cnt_q <= 16'h0000;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Self-checking bench for cmp_rr_scheduler: directed scenarios plus random traffic against a
// queue-based reference model; the comparator is modelled as a 3-cycle registered FP compare.
`timescale 1ns/1ps
module tb_cmp_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int LAT   = 3;
    localparam int OPW   = WIDTH + 1;
    localparam logic [16:0] ONE = 17'h09FF8;
    localparam logic [16:0] TWO = 17'h0A000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    cmp_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
`ifdef CMP_RR_STAT_EN
    logic [15:0] grant_cnt;
    logic [15:0] conflict_cnt;
`endif

    cmp_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave)
`ifdef CMP_RR_STAT_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [NREQ-1:0] v;
    logic [OPW-1:0]  a_op [NREQ];
    logic [OPW-1:0]  b_op [NREQ];

    always_comb begin
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*OPW +: OPW] = a_op[i];
            bus.req_b[i*OPW +: OPW] = b_op[i];
        end
    end

    // Ordering key of a FloPoCo value: zero, normal (exp,frac), infinity; sign applied afterwards.
    function automatic int fp_key(input logic [16:0] x);
        int m;
        case (x[16:15])
            2'b00:   m = 0;
            2'b01:   m = 1 + int'(x[13:0]);
            2'b10:   m = 100000;
            default: m = 0;
        endcase
        return x[14] ? -m : m;
    endfunction

    function automatic bit fp_gt(input logic [16:0] x, input logic [16:0] y);
        if (x[16:15] == 2'b11 || y[16:15] == 2'b11) return 1'b0;
        return fp_key(x) > fp_key(y);
    endfunction

    function automatic logic [16:0] rand_op();
        int          r;
        logic [1:0]  exn;
        logic [10:0] e;
        logic [2:0]  f;
        r   = $urandom_range(0, 15);
        exn = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
        e   = 11'(1022 + $urandom_range(0, 3));
        f   = 3'($urandom_range(0, 7));
        return {exn, 1'($urandom_range(0, 1)), e, f};
    endfunction

    // Comparator: operands seen in cycle c produce the result during cycle c+LAT.
    logic c1, c2;
    always @(posedge clk) begin
        c1              <= fp_gt(bus.cmp_a, bus.cmp_b);
        c2              <= c1;
        bus.cmp_greater <= c2;
    end

    // Reference model state
    typedef struct { int idx; bit gt; int due; } rsp_t;
    rsp_t            m_q[$];
    int              m_ptr = 0;
    int              m_grant = -1;
    int              cyc = 0;
    logic [OPW-1:0]  m_cmp_a = '0;
    logic [OPW-1:0]  m_cmp_b = '0;
    logic [NREQ-1:0] e_ready, e_rv;
    logic            e_rg;
    logic [OPW-1:0]  e_ca, e_cb;

    task automatic model_eval();
        e_ca = m_cmp_a;
        e_cb = m_cmp_b;
        e_rv = '0;
        e_rg = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            e_rv[m_q[0].idx] = 1'b1;
            e_rg = m_q[0].gt;
            void'(m_q.pop_front());
        end
        e_ready = '0;
        m_grant = -1;
        if (!rst) begin
            m_q.delete();
            m_ptr   = 0;
            m_cmp_a = '0;
            m_cmp_b = '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_grant < 0 && v[(m_ptr + k) % NREQ]) m_grant = (m_ptr + k) % NREQ;
            end
            if (m_grant >= 0) begin
                e_ready[m_grant] = 1'b1;
                m_q.push_back('{idx: m_grant, gt: fp_gt(a_op[m_grant], b_op[m_grant]), due: cyc + LAT + 2});
                m_ptr   = (m_grant + 1) % NREQ;
                m_cmp_a = a_op[m_grant];
                m_cmp_b = b_op[m_grant];
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic new_ops(input int i);
        a_op[i] = rand_op();
        b_op[i] = rand_op();
    endtask

    task automatic quick_reset();
        rst = 1'b0;
        v   = '0;
        sample();
        checks++;
        if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg)
            begin fails++; $display("FAIL qreset cyc %0d got rdy=%b rv=%b rg=%b want rdy=%b rv=%b rg=%b", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, e_ready, e_rv, e_rg); end
        advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        v   = 4'hF;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (bus.req_ready !== 4'h0) begin fails++; $display("FAIL reset_ready cyc %0d got %b want 0000", cyc, bus.req_ready); end
            checks++;
            if (bus.rsp_valid !== 4'h0 || bus.rsp_greater !== 1'b0) begin fails++; $display("FAIL reset_rsp cyc %0d got rv=%b rg=%b want 0000/0", cyc, bus.rsp_valid, bus.rsp_greater); end
            checks++;
            if (bus.cmp_a !== 17'h0 || bus.cmp_b !== 17'h0) begin fails++; $display("FAIL reset_cmp cyc %0d got a=%h b=%h want 0/0", cyc, bus.cmp_a, bus.cmp_b); end
            advance();
        end
        rst = 1'b1;
        v   = '0;
    endtask

    task automatic test_single(input logic [16:0] a, input logic [16:0] b, input bit want);
        logic [NREQ-1:0] want_rv;
        v       = 4'b0001;
        a_op[0] = a;
        b_op[0] = b;
        for (int k = 0; k <= 6; k++) begin
            sample();
            if (k == 0) begin
                checks++;
                if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
            end
            if (k == 1) begin
                checks++;
                if (bus.cmp_a !== a || bus.cmp_b !== b) begin fails++; $display("FAIL single_issue got a=%h b=%h want a=%h b=%h", bus.cmp_a, bus.cmp_b, a, b); end
            end
            want_rv = (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.rsp_valid !== want_rv || bus.rsp_greater !== ((k == 5) ? want : 1'b0))
                begin fails++; $display("FAIL single_rsp k=%0d got rv=%b rg=%b want rv=%b rg=%b", k, bus.rsp_valid, bus.rsp_greater, want_rv, (k == 5) ? want : 1'b0); end
            advance();
            v = 4'b0000;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        quick_reset();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        v = 4'hF;
        for (int k = 0; k < 15; k++) begin
            sample();
            if (k < 8) begin
                want = 4'(1 << (k % 4));
                checks++;
                if (bus.req_ready !== want) begin fails++; $display("FAIL rr_grant k=%0d got %b want %b", k, bus.req_ready, want); end
            end
            want = (k >= 5 && k < 13) ? 4'(1 << ((k - 5) % 4)) : 4'b0000;
            checks++;
            if (bus.rsp_valid !== want) begin fails++; $display("FAIL rr_order k=%0d got %b want %b", k, bus.rsp_valid, want); end
            checks++;
            if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg || bus.cmp_a !== e_ca || bus.cmp_b !== e_cb)
                begin fails++; $display("FAIL rr_model cyc %0d got rdy=%b rv=%b rg=%b a=%h b=%h want rdy=%b rv=%b rg=%b a=%h b=%h", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, bus.cmp_a, bus.cmp_b, e_ready, e_rv, e_rg, e_ca, e_cb); end
            advance();
            if (m_grant >= 0) new_ops(m_grant);
            if (k == 7) v = '0;
        end
    endtask

    task automatic test_pattern();
        logic [NREQ-1:0] want_seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b0010};
        quick_reset();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        v = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (k < 4) begin
                checks++;
                if (bus.req_ready !== want_seq[k]) begin fails++; $display("FAIL pat_grant k=%0d got %b want %b", k, bus.req_ready, want_seq[k]); end
            end
            checks++;
            if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg || bus.cmp_a !== e_ca || bus.cmp_b !== e_cb)
                begin fails++; $display("FAIL pat_model cyc %0d got rdy=%b rv=%b rg=%b want rdy=%b rv=%b rg=%b", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, e_ready, e_rv, e_rg); end
            advance();
            if (m_grant >= 0) new_ops(m_grant);
            if (k == 1) v = 4'b0010;
            if (k == 3) v = 4'b0000;
        end
    endtask

    task automatic test_reset_mid();
        v       = 4'b0100;
        a_op[2] = TWO;
        b_op[2] = ONE;
        for (int k = 0; k < 9; k++) begin
            sample();
            if (k == 0) begin
                checks++;
                if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL mid_grant got %b want 0100", bus.req_ready); end
            end
            if (k >= 3) begin
                checks++;
                if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL mid_flush k=%0d got %b want 0000", k, bus.rsp_valid); end
            end
            checks++;
            if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg)
                begin fails++; $display("FAIL mid_model cyc %0d got rdy=%b rv=%b rg=%b want rdy=%b rv=%b rg=%b", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, e_ready, e_rv, e_rg); end
            advance();
            v   = '0;
            rst = (k == 1) ? 1'b0 : 1'b1;
        end
        v = 4'b0100;
        for (int k = 0; k <= 6; k++) begin
            sample();
            checks++;
            if (bus.rsp_valid !== ((k == 5) ? 4'b0100 : 4'b0000) || bus.rsp_greater !== (k == 5))
                begin fails++; $display("FAIL mid_after k=%0d got rv=%b rg=%b want rv=%b rg=%b", k, bus.rsp_valid, bus.rsp_greater, (k == 5) ? 4'b0100 : 4'b0000, k == 5); end
            advance();
            v = '0;
        end
    endtask

    task automatic test_random();
        int wait_c [NREQ];
        quick_reset();
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        for (int k = 0; k < 408; k++) begin
            sample();
            checks++;
            if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg || bus.cmp_a !== e_ca || bus.cmp_b !== e_cb)
                begin fails++; $display("FAIL rand_model cyc %0d got rdy=%b rv=%b rg=%b a=%h b=%h want rdy=%b rv=%b rg=%b a=%h b=%h", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, bus.cmp_a, bus.cmp_b, e_ready, e_rv, e_rg, e_ca, e_cb); end
            if (m_grant >= 0) begin
                checks++;
                if (wait_c[m_grant] > NREQ - 1) begin fails++; $display("FAIL rand_wait req %0d waited %0d want <= %0d", m_grant, wait_c[m_grant], NREQ - 1); end
                wait_c[m_grant] = 0;
            end
            for (int i = 0; i < NREQ; i++) if (v[i] && i != m_grant) wait_c[i]++;
            advance();
            if (k >= 400) begin
                v = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (i == m_grant) begin
                        v[i] = 1'($urandom_range(0, 1));
                        new_ops(i);
                    end else if (!v[i] && $urandom_range(0, 9) < 3) begin
                        v[i] = 1'b1;
                        new_ops(i);
                    end
                end
            end
        end
        checks++;
        if (m_q.size() != 0) begin fails++; $display("FAIL rand_drain got %0d outstanding want 0", m_q.size()); end
    endtask

`ifdef CMP_RR_STAT_EN
    task automatic test_stats();
        quick_reset();
        v = 4'hF;
        for (int k = 0; k < 20; k++) begin
            sample();
            checks++;
            if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv || bus.rsp_greater !== e_rg)
                begin fails++; $display("FAIL stat_model cyc %0d got rdy=%b rv=%b rg=%b want rdy=%b rv=%b rg=%b", cyc, bus.req_ready, bus.rsp_valid, bus.rsp_greater, e_ready, e_rv, e_rg); end
            advance();
            if (m_grant >= 0) new_ops(m_grant);
            if (k == 9) begin
                checks++;
                if (grant_cnt !== 16'd10 || conflict_cnt !== 16'd10) begin fails++; $display("FAIL stat_count got g=%0d c=%0d want 10/10", grant_cnt, conflict_cnt); end
                dut.grant_cnt_q    <= 16'hFFFE;
                dut.conflict_cnt_q <= 16'hFFFE;
            end
            if (k == 12) begin
                checks++;
                if (grant_cnt !== 16'hFFFF || conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL stat_sat got g=%h c=%h want FFFF/FFFF", grant_cnt, conflict_cnt); end
                v = '0;
            end
        end
    endtask
`endif

    initial begin
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single(TWO, ONE, 1'b1);
        test_single(ONE, ONE, 1'b0);
        test_round_robin();
        test_pattern();
        test_reset_mid();
        test_random();
`ifdef CMP_RR_STAT_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
